// File: rtl/mul_req_arbiter_if.sv
// Handshake bundle between the UART/SPI framers, the shared multiplier and the arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface mul_req_arbiter_if #(
    parameter int unsigned W = 8
);
    logic           uart_req_valid;
    logic [W-1:0]   uart_req_a;
    logic [W-1:0]   uart_req_b;
    logic           uart_req_ready;

    logic           spi_req_valid;
    logic [W-1:0]   spi_req_a;
    logic [W-1:0]   spi_req_b;
    logic           spi_req_ready;

    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_done;
    logic [2*W-1:0] mul_result;

    logic           uart_rsp_valid;
    logic [2*W-1:0] uart_rsp_data;
    logic           uart_rsp_err;
    logic           uart_rsp_ready;

    logic           spi_rsp_valid;
    logic [2*W-1:0] spi_rsp_data;
    logic           spi_rsp_err;
    logic           spi_rsp_ready;

    logic           busy;
    logic           grant_spi;

    modport slave (
        input  uart_req_valid, uart_req_a, uart_req_b,
        output uart_req_ready,
        input  spi_req_valid, spi_req_a, spi_req_b,
        output spi_req_ready,
        output mul_start, mul_a, mul_b,
        input  mul_done, mul_result,
        output uart_rsp_valid, uart_rsp_data, uart_rsp_err,
        input  uart_rsp_ready,
        output spi_rsp_valid, spi_rsp_data, spi_rsp_err,
        input  spi_rsp_ready,
        output busy, grant_spi
    );

    modport master (
        output uart_req_valid, uart_req_a, uart_req_b,
        input  uart_req_ready,
        output spi_req_valid, spi_req_a, spi_req_b,
        input  spi_req_ready,
        input  mul_start, mul_a, mul_b,
        output mul_done, mul_result,
        input  uart_rsp_valid, uart_rsp_data, uart_rsp_err,
        output uart_rsp_ready,
        input  spi_rsp_valid, spi_rsp_data, spi_rsp_err,
        output spi_rsp_ready,
        input  busy, grant_spi
    );
endinterface

// File: rtl/mul_req_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between UART and SPI requesters,
// with a WAIT timeout that turns a missing mul_done into an error response.
module mul_req_arbiter #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    mul_req_arbiter_if.slave bus
);
    localparam int unsigned   TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           last_spi;
    logic           grant_q;
    logic [TW-1:0]  timer;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] uart_data_q;
    logic [2*W-1:0] spi_data_q;
    logic           uart_err_q;
    logic           spi_err_q;

    logic           pick_spi;
    logic           accept;
    logic           load_rsp;
    logic           rsp_ok;
    logic           finish;

    // SPI wins when it is alone, or on a tie when UART was served last.
    assign pick_spi = bus.spi_req_valid && (!bus.uart_req_valid || !last_spi);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_rsp  = 1'b0;
        rsp_ok    = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by reset so no ready escapes while reset is held.
                if (reset && (bus.uart_req_valid || bus.spi_req_valid)) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mul_done) begin
                    load_rsp  = 1'b1;
                    rsp_ok    = 1'b1;
                    state_nxt = ST_RESPOND;
                end else if (timer == LAST) begin
                    load_rsp  = 1'b1;
                    state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (grant_q ? bus.spi_rsp_ready : bus.uart_rsp_ready) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_spi    <= 1'b1;
            grant_q     <= 1'b0;
            timer       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            uart_data_q <= '0;
            spi_data_q  <= '0;
            uart_err_q  <= 1'b0;
            spi_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                grant_q <= pick_spi;
                a_q     <= pick_spi ? bus.spi_req_a : bus.uart_req_a;
                b_q     <= pick_spi ? bus.spi_req_b : bus.uart_req_b;
            end

            if (state == ST_ISSUE) begin
                timer <= '0;
            end else if (state == ST_WAIT) begin
                timer <= timer + TW'(1);
            end

            // Done in the expiry cycle still counts as success.
            if (load_rsp) begin
                if (grant_q) begin
                    spi_data_q <= rsp_ok ? bus.mul_result : '0;
                    spi_err_q  <= !rsp_ok;
                end else begin
                    uart_data_q <= rsp_ok ? bus.mul_result : '0;
                    uart_err_q  <= !rsp_ok;
                end
            end

            if (finish) begin
                last_spi <= grant_q;
            end
        end
    end

    assign bus.uart_req_ready = accept && !pick_spi;
    assign bus.spi_req_ready  = accept && pick_spi;

    assign bus.mul_start = (state == ST_ISSUE);
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;

    assign bus.uart_rsp_valid = (state == ST_RESPOND) && !grant_q;
    assign bus.uart_rsp_data  = uart_data_q;
    assign bus.uart_rsp_err   = uart_err_q;
    assign bus.spi_rsp_valid  = (state == ST_RESPOND) && grant_q;
    assign bus.spi_rsp_data   = spi_data_q;
    assign bus.spi_rsp_err    = spi_err_q;

    assign bus.busy      = (state != ST_IDLE);
    assign bus.grant_spi = grant_q;
endmodule
